uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10: clk cycles per serial bit period; legal range 4..255.
REQ-002 Parameter START_OFFSET, default 0: initial value of the bit-period counter on entry to RECEIVE; legal range 0..CLKS_PER_BIT-1.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 serial_in  in  1  raw asynchronous UART line; idles high.
REQ-007 stop_bit  in  1  stop-bit value from the downstream 9-bit receive shift register.
REQ-008 shift_strobe  out  1  one-cycle pulse that advances the 9-bit shift register.
REQ-009 sbc_clear  out  1  one-cycle pulse at frame start that clears downstream error/stop logic.
REQ-010 load_buffer  out  1  one-cycle pulse that commits packet_data to the receive buffer.
REQ-011 framing_error  out  1  sticky flag: the last frame had stop_bit = 0.
REQ-012 rx_busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-013 Synchronise serial_in through two flops, both reset to 1.
REQ-014 Start edge = previous synchronised sample 1 AND current synchronised sample 0; the edge is acted on only in IDLE.
REQ-015 FSM states: IDLE, START, RECEIVE, STOP_CHK, LOAD, ERR.
REQ-016 IDLE -> START on a start edge; otherwise stay in IDLE.
REQ-017 START lasts one cycle: sbc_clear = 1, framing_error cleared; then -> RECEIVE.
REQ-018 On entry to RECEIVE: clk_cnt = START_OFFSET and bit_cnt = 0.
REQ-019 In RECEIVE, clk_cnt increments each cycle. When clk_cnt == CLKS_PER_BIT-1: shift_strobe = 1, clk_cnt wraps to 0, bit_cnt increments.
REQ-020 With defaults, the first strobe is on the 10th RECEIVE cycle and later strobes are exactly CLKS_PER_BIT cycles apart.
REQ-021 Exactly 9 strobes per frame (8 data + stop). On the cycle the 9th strobe is issued, next state = STOP_CHK.
REQ-022 STOP_CHK (1 cycle) samples stop_bit, which is valid after the 9th strobe edge.
  - stop_bit = 1 -> LOAD.
  - stop_bit = 0 -> ERR.
REQ-023 LOAD (1 cycle): load_buffer = 1; -> IDLE.
REQ-024 ERR (1 cycle): framing_error set to 1, load_buffer stays 0; -> IDLE.
REQ-025 framing_error holds its value until the next START or reset.
REQ-026 Line activity outside IDLE is ignored: no restart and no extra strobes.
REQ-027 An edge detected while not in IDLE is not queued. A line still low on return to IDLE does not start a frame without a fresh 1->0 transition.
REQ-028 shift_strobe, sbc_clear and load_buffer are registered, mutually exclusive, and never high for two consecutive cycles.
REQ-029 clk_cnt is sized ceil(log2(CLKS_PER_BIT)) bits; bit_cnt is 4 bits. Neither exceeds its terminal value.

Reset
REQ-030 rst = 1 forces immediately, independent of clk:
  - state = IDLE;
  - clk_cnt = 0, bit_cnt = 0;
  - sync flops = 1;
  - shift_strobe, sbc_clear, load_buffer, framing_error, rx_busy = 0.
REQ-031 Reset mid-frame abandons the frame with no load_buffer pulse. The first start edge after rst deasserts begins a complete new frame.

Structure
REQ-032 Package uart_rx_pkg holds the FSM state enum, and the default CLKS_PER_BIT and bit count (9) constants.
REQ-033 One sub-module, rx_timer, holds clk_cnt, bit_cnt, strobe generation and the 9-strobe done indication, enabled by the FSM while in RECEIVE.
REQ-034 The FSM, synchroniser and edge detector live in uart_rx_ctrl.

Verification
REQ-035 Reset: assert rst mid-simulation -> all outputs 0 within the same cycle; rx_busy = 0.
REQ-036 Frame 0xA5, stop = 1, defaults -> all of:
  - sbc_clear pulses 3 cycles after the line falls;
  - 9 strobes 10 cycles apart;
  - load_buffer pulses 2 cycles after the 9th strobe;
  - framing_error = 0.
REQ-037 Frame with stop = 0 -> framing_error = 1, no load_buffer; the next valid frame's START clears it.
REQ-038 rst asserted after the 4th strobe, then a full frame sent -> 9 strobes and one load_buffer for the new frame only.
REQ-039 Line toggles 1->0->1 during RECEIVE -> still exactly 9 strobes, no extra sbc_clear.
REQ-040 Two back-to-back frames (second start bit immediately after the first stop bit) -> two load_buffer pulses, 18 strobes, framing_error = 0.

Source files
------------

// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_pkg
// Brief   : Shared FSM state encoding and frame constants for the UART RX
//           control slice.
// Revision: 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    localparam int c_CLKS_PER_BIT_DEF = 10;
    localparam int c_FRAME_BITS       = 9;
    localparam int c_BIT_CNT_W        = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_RECEIVE  = 3'd2,
        ST_STOP_CHK = 3'd3,
        ST_LOAD     = 3'd4,
        ST_ERR      = 3'd5
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_ctrl_rx_timer.sv
`default_nettype none
// ============================================================================
// Module  : rx_timer
// Brief   : Bit-period counter, strobe generator and end-of-frame indication.
// Revision: 1.0 - initial release
// ============================================================================
module rx_timer
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_CLKS_PER_BIT_DEF,
    parameter int START_OFFSET = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic strobe_o,
    output logic done_o
);

    localparam int                       CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]         c_TERM     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]         c_PRE_TERM = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [CNT_W-1:0]         c_OFFSET   = CNT_W'(START_OFFSET);
    localparam logic [c_BIT_CNT_W-1:0]   c_LAST_BIT = c_BIT_CNT_W'(c_FRAME_BITS - 1);
    localparam logic [c_BIT_CNT_W-1:0]   c_MAX_BIT  = c_BIT_CNT_W'(c_FRAME_BITS);

    logic [CNT_W-1:0]       clk_cnt_q;
    logic [c_BIT_CNT_W-1:0] bit_cnt_q;
    logic                   strobe_q;

    // The strobe is registered one cycle ahead so that it is high exactly
    // while clk_cnt sits at its terminal value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            strobe_q  <= 1'b0;
        end else if (load_i) begin
            clk_cnt_q <= c_OFFSET;
            bit_cnt_q <= '0;
            strobe_q  <= (c_OFFSET == c_TERM);
        end else if (en_i) begin
            if (clk_cnt_q == c_TERM) begin
                clk_cnt_q <= '0;
                if (bit_cnt_q != c_MAX_BIT) begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end
            end else begin
                clk_cnt_q <= clk_cnt_q + 1'b1;
            end
            strobe_q <= (clk_cnt_q == c_PRE_TERM);
        end else begin
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            strobe_q  <= 1'b0;
        end
    end

    assign strobe_o = strobe_q;
    assign done_o   = strobe_q && (bit_cnt_q == c_LAST_BIT);

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_ctrl
// Brief   : UART receive control FSM with input synchroniser, start-edge
//           detection and framing-error tracking.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_CLKS_PER_BIT_DEF,
    parameter int START_OFFSET = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic serial_in,
    input  logic stop_bit,
    output logic shift_strobe,
    output logic sbc_clear,
    output logic load_buffer,
    output logic framing_error,
    output logic rx_busy
);

    logic [1:0] sync_q;
    logic       prev_q;
    logic       w_start_edge;
    logic       w_strobe;
    logic       w_done;

    rx_state_e  state_q;
    logic       sbc_clear_q;
    logic       load_buffer_q;
    logic       framing_error_q;
    logic       rx_busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], serial_in};
            prev_q <= sync_q[1];
        end
    end

    assign w_start_edge = prev_q & ~sync_q[1];

    rx_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .START_OFFSET (START_OFFSET)
    ) u_rx_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (state_q == ST_START),
        .en_i     (state_q == ST_RECEIVE),
        .strobe_o (w_strobe),
        .done_o   (w_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            sbc_clear_q     <= 1'b0;
            load_buffer_q   <= 1'b0;
            framing_error_q <= 1'b0;
            rx_busy_q       <= 1'b0;
        end else begin
            sbc_clear_q   <= 1'b0;
            load_buffer_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_start_edge) begin
                        state_q         <= ST_START;
                        sbc_clear_q     <= 1'b1;
                        framing_error_q <= 1'b0;
                        rx_busy_q       <= 1'b1;
                    end
                end
                ST_START: begin
                    state_q <= ST_RECEIVE;
                end
                ST_RECEIVE: begin
                    if (w_done) begin
                        state_q <= ST_STOP_CHK;
                    end
                end
                // stop_bit has settled after the final strobe edge.
                ST_STOP_CHK: begin
                    if (stop_bit) begin
                        state_q       <= ST_LOAD;
                        load_buffer_q <= 1'b1;
                    end else begin
                        state_q         <= ST_ERR;
                        framing_error_q <= 1'b1;
                    end
                end
                ST_LOAD, ST_ERR: begin
                    state_q   <= ST_IDLE;
                    rx_busy_q <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    rx_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign shift_strobe  = w_strobe;
    assign sbc_clear     = sbc_clear_q;
    assign load_buffer   = load_buffer_q;
    assign framing_error = framing_error_q;
    assign rx_busy       = rx_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx_ctrl
// Brief   : Randomised scoreboard bench for uart_rx_ctrl with a downstream
//           shift-register model supplying stop_bit.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

    localparam int c_CPB = 10;
    localparam int c_SO  = 0;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic serial_in = 1'b1;
    logic stop_bit;
    logic shift_strobe, sbc_clear, load_buffer, framing_error, rx_busy;

    uart_rx_ctrl #(
        .CLKS_PER_BIT (c_CPB),
        .START_OFFSET (c_SO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .stop_bit      (stop_bit),
        .shift_strobe  (shift_strobe),
        .sbc_clear     (sbc_clear),
        .load_buffer   (load_buffer),
        .framing_error (framing_error),
        .rx_busy       (rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream 9-bit shift register fed from its own synchronised copy of the line
    logic [1:0] ls    = 2'b11;
    logic [8:0] shreg = '0;
    always @(posedge clk) begin
        ls <= {ls[0], serial_in};
        if (shift_strobe) shreg <= {ls[1], shreg[8:1]};
    end
    assign stop_bit = shreg[8];

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       stop;
    } exp_t;

    exp_t res_q[$];
    int   sbc_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic hold(input logic v, input int n);
        serial_in = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called 1 time unit after a rising edge; abort_bits>0 stops after that many data bits.
    task automatic send_frame(input logic [7:0] data, input logic stop, input bit glitch,
                              input int abort_bits);
        int   fall;
        exp_t e;
        fall = cyc;
        sbc_q.push_back(fall + 3);
        if (abort_bits == 0) begin
            e.cyc  = fall + 3 + 1 + (c_CPB - 1 - c_SO) + 8 * c_CPB + 2;
            e.data = data;
            e.stop = stop;
            res_q.push_back(e);
        end
        hold(1'b0, c_CPB);
        for (int i = 0; i < 8; i++) begin
            if (abort_bits != 0 && i == abort_bits) return;
            if (glitch && data[i]) begin
                hold(1'b1, 3);
                hold(1'b0, 2);
                hold(1'b1, c_CPB - 5);
            end else begin
                hold(data[i], c_CPB);
            end
        end
        hold(stop, c_CPB);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_shift_strobe"},  shift_strobe,  0);
        chk({tag, "_sbc_clear"},     sbc_clear,     0);
        chk({tag, "_load_buffer"},   load_buffer,   0);
        chk({tag, "_framing_error"}, framing_error, 0);
        chk({tag, "_rx_busy"},       rx_busy,       0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a pulse
    int   fr_strobes  = 0;
    int   last_strobe = 0;
    int   last_sbc    = 0;
    logic p_ss = 0, p_sbc = 0, p_ld = 0, p_fe = 0;
    exp_t m_e;

    always @(negedge clk) begin
        if (rst) begin
            fr_strobes = 0;
            p_ss = 0; p_sbc = 0; p_ld = 0; p_fe = 0;
        end else begin
            if (shift_strobe | sbc_clear | load_buffer) begin
                chk("pulse_onehot", $countones({shift_strobe, sbc_clear, load_buffer}), 1);
                chk("pulse_consecutive",
                    (shift_strobe & p_ss) | (sbc_clear & p_sbc) | (load_buffer & p_ld), 0);
            end
            if (sbc_clear) begin
                chk("sbc_expected", sbc_q.size() > 0, 1);
                if (sbc_q.size() > 0) chk("sbc_cycle", cyc, sbc_q.pop_front());
                chk("fe_clear_at_start", framing_error, 0);
                chk("busy_at_start", rx_busy, 1);
                fr_strobes = 0;
                last_sbc   = cyc;
            end
            if (shift_strobe) begin
                fr_strobes++;
                if (fr_strobes == 1) chk("first_strobe_cycle", cyc, last_sbc + 1 + (c_CPB - 1 - c_SO));
                else                 chk("strobe_spacing", cyc - last_strobe, c_CPB);
                chk("strobe_count_max", fr_strobes <= 9, 1);
                last_strobe = cyc;
            end
            if (load_buffer || (framing_error && !p_fe)) begin
                chk("result_expected", res_q.size() > 0, 1);
                if (res_q.size() > 0) begin
                    m_e = res_q.pop_front();
                    chk("result_cycle", cyc, m_e.cyc);
                    chk("result_kind_load", load_buffer, m_e.stop);
                    if (load_buffer) chk("load_data", shreg[7:0], m_e.data);
                    chk("frame_strobes", fr_strobes, 9);
                end
            end
            p_ss  = shift_strobe;
            p_sbc = sbc_clear;
            p_ld  = load_buffer;
            p_fe  = framing_error;
        end
    end

    initial begin
        logic [7:0] d;
        logic       s;
        bit         g;
        rst       = 1'b1;
        serial_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset_init");
        rst = 1'b0;
        hold(1'b1, 5);

        send_frame(8'hA5, 1'b1, 1'b0, 0);
        hold(1'b1, 3);
        chk("fe_after_good", framing_error, 0);

        send_frame(8'h3C, 1'b0, 1'b0, 0);
        hold(1'b1, 8);
        chk("fe_sticky", framing_error, 1);
        chk("busy_idle_after_err", rx_busy, 0);

        send_frame(8'h5A, 1'b1, 1'b0, 0);
        hold(1'b1, 3);
        chk("fe_cleared_by_good", framing_error, 0);

        send_frame(8'h00, 1'b0, 1'b0, 0);
        hold(1'b1, 8);
        chk("fe_before_reset", framing_error, 1);
        rst = 1'b1;
        #1;
        chk_all_zero("reset_idle");
        @(posedge clk);
        #1;
        rst = 1'b0;
        hold(1'b1, 3);

        send_frame(8'hC3, 1'b1, 1'b0, 4);
        chk("busy_before_abort", rx_busy, 1);
        rst       = 1'b1;
        serial_in = 1'b1;
        #1;
        chk_all_zero("reset_midframe");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        hold(1'b1, 4);
        send_frame(8'h96, 1'b1, 1'b0, 0);
        hold(1'b1, 3);

        send_frame(8'hF0, 1'b1, 1'b1, 0);
        hold(1'b1, 3);

        send_frame(8'h12, 1'b1, 1'b0, 0);
        send_frame(8'hED, 1'b1, 1'b0, 0);
        hold(1'b1, 3);
        chk("fe_after_back_to_back", framing_error, 0);

        for (int k = 0; k < 10; k++) begin
            d = 8'($urandom);
            s = ($urandom_range(0, 3) != 0);
            g = 1'($urandom_range(0, 1));
            send_frame(d, s, g, 0);
            hold(1'b1, s ? $urandom_range(0, 4) : $urandom_range(2, 5));
        end

        for (int i = 0; i < 300 && (res_q.size() > 0 || sbc_q.size() > 0); i++) @(posedge clk);
        #1;
        chk("results_drained", res_q.size(), 0);
        chk("sbc_drained", sbc_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
